// File: rtl/onion_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onion_pwm_pkg
// Brief    : Shared encodings and helpers for the multi-channel PWM block.
// Revision : 1.0
// ============================================================================
package onion_pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // One extra bit lets a duty of MAX+1 express "always high".
    function automatic int DUTY_W(input int res);
        return res + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onion_pwm_if.sv
`default_nettype none
// ============================================================================
// Module   : onion_pwm_if
// Brief    : Control inputs and PWM outputs of the multi-channel PWM block.
// Revision : 1.0
// ============================================================================
interface onion_pwm_if
    import onion_pwm_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int RES_BITS      = 8,
    parameter int PRESCALE_BITS = 8
);
    localparam int DW = DUTY_W(RES_BITS);

    logic                     enable;
    logic                     center_mode;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [NUM_CH*DW-1:0]     duty_in;
    logic [NUM_CH-1:0]        duty_wr;
    logic [NUM_CH-1:0]        polarity;
    logic [NUM_CH-1:0]        PWM_o;
    logic                     period_start_o;

    modport master (
        output enable, center_mode, prescale, duty_in, duty_wr, polarity,
        input  PWM_o, period_start_o
    );

    modport slave (
        input  enable, center_mode, prescale, duty_in, duty_wr, polarity,
        output PWM_o, period_start_o
    );

endinterface
`default_nettype wire

// File: rtl/onion_pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module   : onion_pwm_timebase
// Brief    : Prescaler plus edge/centre-aligned counter with period boundary.
// Revision : 1.0
// ============================================================================
module onion_pwm_timebase
    import onion_pwm_pkg::*;
#(
    parameter int RES_BITS      = 8,
    parameter int PRESCALE_BITS = 8
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     enable_i,
    input  wire logic                     center_mode_i,
    input  wire logic [PRESCALE_BITS-1:0] prescale_i,
    output logic      [RES_BITS-1:0]      cnt_o,
    output logic                          boundary_o,
    output logic                          enable_q_o
);
    localparam logic [RES_BITS-1:0] CNT_MAX = '1;
    localparam logic [RES_BITS-1:0] CNT_ONE = RES_BITS'(1);

    logic [PRESCALE_BITS-1:0] pcnt_q, pcnt_d;
    logic [RES_BITS-1:0]      cnt_q, cnt_d;
    dir_e                     dir_q, dir_d;
    logic                     mode_q, mode_d;
    logic                     enable_q;
    logic                     w_run, w_tick, w_boundary;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            mode_q   <= MODE_EDGE;
            enable_q <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            enable_q <= enable_i;
        end
    end

    // The first enabled cycle holds cnt at 0 so the first period is complete
    // once the output stage (driven by enable_q) starts following the compare.
    always_comb begin
        pcnt_d     = pcnt_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        w_run      = enable_i & enable_q;
        w_tick     = w_run && (pcnt_q >= prescale_i);
        w_boundary = w_tick && ((mode_q == MODE_EDGE) ? (cnt_q == CNT_MAX)
                                                      : (dir_q == DIR_DOWN && cnt_q == CNT_ONE));
        if (!w_run) begin
            pcnt_d = '0;
            cnt_d  = '0;
            dir_d  = DIR_UP;
            mode_d = center_mode_i;
        end else begin
            pcnt_d = w_tick ? '0 : pcnt_q + PRESCALE_BITS'(1);
            if (w_boundary) begin
                cnt_d  = '0;
                dir_d  = DIR_UP;
                mode_d = center_mode_i;
            end else if (w_tick) begin
                if (mode_q == MODE_EDGE || (dir_q == DIR_UP && cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    dir_d = DIR_DOWN;
                end
            end
        end
    end

    assign cnt_o      = cnt_q;
    assign boundary_o = w_boundary;
    assign enable_q_o = enable_q;

endmodule
`default_nettype wire

// File: rtl/onion_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : onion_pwm_multi
// Brief    : Multi-channel PWM with shared timebase and shadowed duty update.
// Revision : 1.0
// ============================================================================
module onion_pwm_multi
    import onion_pwm_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int RES_BITS      = 8,
    parameter int PRESCALE_BITS = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    onion_pwm_if.slave bus
);
    localparam int DW = DUTY_W(RES_BITS);

    logic [RES_BITS-1:0] w_cnt;
    logic                w_boundary;
    logic                w_enable_q;
    logic                period_start_q;

    onion_pwm_timebase #(
        .RES_BITS      (RES_BITS),
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_timebase (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (bus.enable),
        .center_mode_i (bus.center_mode),
        .prescale_i    (bus.prescale),
        .cnt_o         (w_cnt),
        .boundary_o    (w_boundary),
        .enable_q_o    (w_enable_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) period_start_q <= 1'b0;
        else        period_start_q <= w_boundary;
    end

    assign bus.period_start_o = period_start_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DW-1:0] staging_q;
        logic [DW-1:0] shadow_q;
        logic          pwm_q;
        logic          w_raw;

        assign w_raw = ({1'b0, w_cnt} < shadow_q);

        // Shadow only moves at the boundary (or while idle), so no runt pulses.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                staging_q <= '0;
                shadow_q  <= '0;
                pwm_q     <= 1'b0;
            end else begin
                if (bus.duty_wr[i])               staging_q <= bus.duty_in[i*DW +: DW];
                if (w_boundary || !bus.enable)    shadow_q  <= staging_q;
                pwm_q <= w_enable_q ? (w_raw ^ bus.polarity[i]) : bus.polarity[i];
            end
        end

        assign bus.PWM_o[i] = pwm_q;
    end

endmodule
`default_nettype wire
